// File: rtl/p03_clock_pkg.sv
// ----------------------------------------------------------------------------
// p03_clock_pkg
//   Shared widths, limits and the BCD time bundle for the clock time keeper
//   and the digit renderer that consumes it.
//
//   Contents:
//     *_W            digit widths for each BCD field
//     MAX_SEC/MIN/HRS decimal value at which each field wraps to 00
//     time_bcd_t     packed HH:MM:SS as six BCD digits (hours tens in MSBs)
//     bcd_tens/bcd_units helpers splitting a decimal limit into digits
// ----------------------------------------------------------------------------
package p03_clock_pkg;

    localparam int SEC_U_W     = 4;
    localparam int SEC_D_W     = 3;
    localparam int MIN_U_W     = 4;
    localparam int MIN_D_W     = 3;
    localparam int HRS_U_W     = 4;
    localparam int HRS_D_W     = 2;
    localparam int COLOR_OFF_W = 4;

    localparam int MAX_SEC = 59;
    localparam int MAX_MIN = 59;
    localparam int MAX_HRS = 23;

    typedef struct packed {
        logic [HRS_D_W-1:0] hrs_d;
        logic [HRS_U_W-1:0] hrs_u;
        logic [MIN_D_W-1:0] min_d;
        logic [MIN_U_W-1:0] min_u;
        logic [SEC_D_W-1:0] sec_d;
        logic [SEC_U_W-1:0] sec_u;
    } time_bcd_t;

    // Tens digit of a decimal limit (elaboration-time use only).
    function automatic int bcd_tens(input int value);
        return value / 10;
    endfunction

    // Units digit of a decimal limit (elaboration-time use only).
    function automatic int bcd_units(input int value);
        return value % 10;
    endfunction

endpackage

// File: rtl/p03_bcd_mod_counter.sv
// ----------------------------------------------------------------------------
// p03_bcd_mod_counter
//   Two-digit BCD counter that counts 00 .. MAX_TENS:MAX_UNITS and wraps to 00.
//   Used for seconds (59), minutes (59) and hours (23).
//
//   Ports:
//     px_clk  in   clock, rising edge
//     reset   in   synchronous, active-high; clears both digits
//     inc     in   advance by exactly one this cycle
//     units   out  registered units digit
//     tens    out  registered tens digit
//     at_max  out  current value equals the wrap point (from registers)
//
//   The wrap point is matched on the current value before incrementing, so
//   the digits never pass through an illegal code such as units = 10 or
//   hours = 24. The units digit always rolls 9 -> 0 with a tens increment
//   unless the whole field is at its maximum, which covers 09 -> 10,
//   19 -> 20 and 23 -> 00 with the same logic.
// ----------------------------------------------------------------------------
module p03_bcd_mod_counter #(
    parameter int UNITS_W   = 4,
    parameter int TENS_W    = 3,
    parameter int MAX_TENS  = 5,
    parameter int MAX_UNITS = 9
) (
    input  logic               px_clk,
    input  logic               reset,
    input  logic               inc,
    output logic [UNITS_W-1:0] units,
    output logic [TENS_W-1:0]  tens,
    output logic               at_max
);

    localparam logic [UNITS_W-1:0] UNITS_LAST = UNITS_W'(MAX_UNITS);
    localparam logic [TENS_W-1:0]  TENS_LAST  = TENS_W'(MAX_TENS);
    localparam logic [UNITS_W-1:0] UNITS_NINE = UNITS_W'(9);

    logic [UNITS_W-1:0] units_q, units_d;
    logic [TENS_W-1:0]  tens_q,  tens_d;
    logic               at_max_w;

    assign at_max_w = (tens_q == TENS_LAST) && (units_q == UNITS_LAST);

    always_comb begin
        units_d = units_q;
        tens_d  = tens_q;
        if (inc) begin
            if (at_max_w) begin
                units_d = '0;
                tens_d  = '0;
            end else if (units_q == UNITS_NINE) begin
                units_d = '0;
                tens_d  = tens_q + TENS_W'(1);
            end else begin
                units_d = units_q + UNITS_W'(1);
            end
        end
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            units_q <= '0;
            tens_q  <= '0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

    assign units  = units_q;
    assign tens   = tens_q;
    assign at_max = at_max_w;

endmodule

// File: rtl/p03_time_keeper.sv
// ----------------------------------------------------------------------------
// p03_time_keeper
//   24-hour BCD HH:MM:SS time keeper feeding the VGA clock digit mux.
//   A prescaler divides px_clk to a once-per-second tick; seconds, minutes
//   and hours are chained BCD counters that also accept one-cycle adjust
//   pulses. A colour offset advances each time the minutes field moves.
//
//   Ports:
//     px_clk        in   pixel clock, rising edge
//     reset         in   synchronous, active-high; clears time, offset,
//                        sec_tick and the prescaler (partial second lost)
//     run           in   1 = prescaler counts, 0 = prescaler holds
//     adj_sec       in   one-cycle pulse, advance seconds (no carry out)
//     adj_min       in   one-cycle pulse, advance minutes (no carry out)
//     adj_hrs       in   one-cycle pulse, advance hours
//     sec_u/sec_d   out  seconds digits
//     min_u/min_d   out  minutes digits
//     hrs_u/hrs_d   out  hours digits
//     color_offset  out  +1 per minutes advance, wraps 15 -> 0
//     sec_tick      out  one-cycle strobe aligned with a tick-driven update
//
//   Interface timing: there is no handshake. All outputs are registers that
//   change one cycle after the tick or pulse that caused them; sec_tick acts
//   as a valid strobe marking the cycle whose time came from the prescaler,
//   and the consumer cannot stall it (no ready / backpressure).
// ----------------------------------------------------------------------------
module p03_time_keeper
    import p03_clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 31_500_000,
    parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
    input  logic                   px_clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   adj_sec,
    input  logic                   adj_min,
    input  logic                   adj_hrs,
    output logic [SEC_U_W-1:0]     sec_u,
    output logic [SEC_D_W-1:0]     sec_d,
    output logic [MIN_U_W-1:0]     min_u,
    output logic [MIN_D_W-1:0]     min_d,
    output logic [HRS_U_W-1:0]     hrs_u,
    output logic [HRS_D_W-1:0]     hrs_d,
    output logic [COLOR_OFF_W-1:0] color_offset,
    output logic                   sec_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    always_comb begin
        tick  = run && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (run) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Carry chain. Carries only propagate from the tick; an adjust pulse
    // that wraps a field deliberately does not disturb the next field.
    // OR-ing tick with adj_sec makes a coincident pair a single +1.
    // ------------------------------------------------------------------
    logic sec_at_max, min_at_max, hrs_at_max;
    logic sec_inc, min_inc, hrs_inc;
    logic sec_carry, min_carry;

    assign sec_inc   = tick | adj_sec;
    assign sec_carry = tick & sec_at_max;
    assign min_inc   = sec_carry | adj_min;
    assign min_carry = sec_carry & min_at_max;
    assign hrs_inc   = min_carry | adj_hrs;

    time_bcd_t time_now;

    p03_bcd_mod_counter #(
        .UNITS_W   (SEC_U_W),
        .TENS_W    (SEC_D_W),
        .MAX_TENS  (bcd_tens(MAX_SEC)),
        .MAX_UNITS (bcd_units(MAX_SEC))
    ) u_sec (
        .px_clk (px_clk),
        .reset  (reset),
        .inc    (sec_inc),
        .units  (time_now.sec_u),
        .tens   (time_now.sec_d),
        .at_max (sec_at_max)
    );

    p03_bcd_mod_counter #(
        .UNITS_W   (MIN_U_W),
        .TENS_W    (MIN_D_W),
        .MAX_TENS  (bcd_tens(MAX_MIN)),
        .MAX_UNITS (bcd_units(MAX_MIN))
    ) u_min (
        .px_clk (px_clk),
        .reset  (reset),
        .inc    (min_inc),
        .units  (time_now.min_u),
        .tens   (time_now.min_d),
        .at_max (min_at_max)
    );

    p03_bcd_mod_counter #(
        .UNITS_W   (HRS_U_W),
        .TENS_W    (HRS_D_W),
        .MAX_TENS  (bcd_tens(MAX_HRS)),
        .MAX_UNITS (bcd_units(MAX_HRS))
    ) u_hrs (
        .px_clk (px_clk),
        .reset  (reset),
        .inc    (hrs_inc),
        .units  (time_now.hrs_u),
        .tens   (time_now.hrs_d),
        .at_max (hrs_at_max)
    );

    // ------------------------------------------------------------------
    // Colour offset and tick strobe
    // ------------------------------------------------------------------
    logic [COLOR_OFF_W-1:0] color_q, color_d;
    logic                   sec_tick_q, sec_tick_d;

    always_comb begin
        color_d    = min_inc ? color_q + COLOR_OFF_W'(1) : color_q;
        sec_tick_d = tick;
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            cnt_q      <= '0;
            color_q    <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    // Digit legality; hours have no carry out, so their at_max is only
    // cross-checked here against the decoded digits.
    always_ff @(posedge px_clk) begin
        if (!reset) begin
            assert (time_now.sec_u <= SEC_U_W'(9) && time_now.sec_d <= SEC_D_W'(5) &&
                    time_now.min_u <= MIN_U_W'(9) && time_now.min_d <= MIN_D_W'(5) &&
                    time_now.hrs_u <= HRS_U_W'(9) && time_now.hrs_d <= HRS_D_W'(2) &&
                    (time_now.hrs_d != HRS_D_W'(2) || time_now.hrs_u <= HRS_U_W'(3)) &&
                    (hrs_at_max == (time_now.hrs_d == HRS_D_W'(2) &&
                                    time_now.hrs_u == HRS_U_W'(3))));
        end
    end

    assign sec_u        = time_now.sec_u;
    assign sec_d        = time_now.sec_d;
    assign min_u        = time_now.min_u;
    assign min_d        = time_now.min_d;
    assign hrs_u        = time_now.hrs_u;
    assign hrs_d        = time_now.hrs_d;
    assign color_offset = color_q;
    assign sec_tick     = sec_tick_q;

endmodule

// File: tb/tb_p03_time_keeper.sv
// ----------------------------------------------------------------------------
// tb_p03_time_keeper
//   Directed bench for p03_time_keeper with TICKS_PER_SEC = 4.
//   Observed word: {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, color, tick}.
//   exp_q/name_q carry point checks issued by the driver; tick_q carries the
//   expected word for every sec_tick strobe the driver causes.
// ----------------------------------------------------------------------------
module tb_p03_time_keeper;

    localparam int W = 25;

    logic       px_clk;
    logic       reset;
    logic       run;
    logic       adj_sec;
    logic       adj_min;
    logic       adj_hrs;
    logic [3:0] sec_u;
    logic [2:0] sec_d;
    logic [3:0] min_u;
    logic [2:0] min_d;
    logic [3:0] hrs_u;
    logic [1:0] hrs_d;
    logic [3:0] color_offset;
    logic       sec_tick;

    p03_time_keeper #(.TICKS_PER_SEC(4)) dut (
        .px_clk       (px_clk),
        .reset        (reset),
        .run          (run),
        .adj_sec      (adj_sec),
        .adj_min      (adj_min),
        .adj_hrs      (adj_hrs),
        .sec_u        (sec_u),
        .sec_d        (sec_d),
        .min_u        (min_u),
        .min_d        (min_d),
        .hrs_u        (hrs_u),
        .hrs_d        (hrs_d),
        .color_offset (color_offset),
        .sec_tick     (sec_tick)
    );

    // ---------------- clock / reset ----------------
    initial begin
        px_clk = 1'b0;
        forever #5 px_clk = ~px_clk;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [W-1:0] tick_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;

    logic [W-1:0] act;
    assign act = {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, color_offset, sec_tick};

    function automatic logic [W-1:0] mk(input int h, input int m, input int s,
                                        input int c, input int t);
        logic [1:0] hd;
        logic [3:0] hu;
        logic [2:0] md;
        logic [3:0] mu;
        logic [2:0] sd;
        logic [3:0] su;
        hd = 2'(h / 10);
        hu = 4'(h % 10);
        md = 3'(m / 10);
        mu = 4'(m % 10);
        sd = 3'(s / 10);
        su = 4'(s % 10);
        return {hd, hu, md, mu, sd, su, 4'(c), 1'(t)};
    endfunction

    function automatic string fmt(input logic [W-1:0] v);
        return $sformatf("%0d%0d:%0d%0d:%0d%0d color=%0d tick=%0d",
                         v[24:23], v[22:19], v[18:16], v[15:12],
                         v[11:9], v[8:5], v[4:1], v[0]);
    endfunction

    // ---------------- monitors ----------------
    initial begin : point_monitor
        logic [W-1:0] e;
        string        nm;
        forever begin
            @(negedge px_clk);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %s, expected %s", nm, fmt(act), fmt(e));
                end
            end
        end
    end

    initial begin : tick_monitor
        logic [W-1:0] e;
        forever begin
            @(negedge px_clk);
            if (sec_tick === 1'b1) begin
                n_cmp++;
                if (tick_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_tick: got %s, expected no sec_tick", fmt(act));
                end else begin
                    e = tick_q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL tick_time: got %s, expected %s", fmt(act), fmt(e));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // which: 0 = seconds, 1 = minutes, 2 = hours; n back-to-back pulses
    task automatic pulse(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            adj_sec = (which == 0);
            adj_min = (which == 1);
            adj_hrs = (which == 2);
            step();
        end
        adj_sec = 1'b0;
        adj_min = 1'b0;
        adj_hrs = 1'b0;
    endtask

    // Runs the prescaler from cnt = 0 for exactly one tick; optionally
    // asserts adj_sec in the tick cycle.
    task automatic do_second(input logic with_adj);
        run = 1'b1;
        repeat (3) step();
        adj_sec = with_adj;
        step();
        adj_sec = 1'b0;
        run     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        run     = 1'b0;
        adj_sec = 1'b0;
        adj_min = 1'b0;
        adj_hrs = 1'b0;
        step();
        step();
        chk("reset_state", mk(0, 0, 0, 0, 0));

        // 40 running cycles: a tick every 4th cycle, first at cycle 4.
        for (int s = 1; s <= 10; s++) tick_q.push_back(mk(0, 0, s, 0, 1));
        reset = 1'b0;
        run   = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 3)  chk("pre_first_tick", mk(0, 0, 0, 0, 0));
            if (i == 4)  chk("first_tick", mk(0, 0, 1, 0, 1));
            if (i == 40) chk("forty_cycles", mk(0, 0, 10, 0, 1));
        end
        run = 1'b0;

        // Preload 00:59:59, then one tick carries into hours.
        pulse(0, 49);
        pulse(1, 59);
        chk("preload_005959", mk(0, 59, 59, 11, 0));
        tick_q.push_back(mk(1, 0, 0, 12, 1));
        do_second(1'b0);
        chk("hour_carry", mk(1, 0, 0, 12, 1));

        // Hours digit sequence by adjust, then midnight rollover on tick.
        pulse(2, 8);
        chk("hrs_09", mk(9, 0, 0, 12, 0));
        pulse(2, 1);
        chk("hrs_10", mk(10, 0, 0, 12, 0));
        pulse(2, 9);
        chk("hrs_19", mk(19, 0, 0, 12, 0));
        pulse(2, 1);
        chk("hrs_20", mk(20, 0, 0, 12, 0));
        pulse(2, 3);
        pulse(1, 59);
        pulse(0, 59);
        chk("preload_235959", mk(23, 59, 59, 7, 0));
        tick_q.push_back(mk(0, 0, 0, 8, 1));
        do_second(1'b0);
        chk("midnight", mk(0, 0, 0, 8, 1));
        pulse(2, 23);
        chk("hrs_23_adj", mk(23, 0, 0, 8, 0));
        pulse(2, 1);
        chk("hrs_adj_wrap", mk(0, 0, 0, 8, 0));

        // Seconds adjust wrap must not carry into minutes.
        do_reset();
        chk("reset_again", mk(0, 0, 0, 0, 0));
        pulse(0, 59);
        chk("adj_sec_59", mk(0, 0, 59, 0, 0));
        pulse(0, 1);
        chk("adj_sec_wrap_nocarry", mk(0, 0, 0, 0, 0));

        // Coincident tick and adj_sec advance by one only.
        pulse(0, 58);
        tick_q.push_back(mk(0, 0, 59, 0, 1));
        do_second(1'b1);
        chk("coincide_at_58", mk(0, 0, 59, 0, 1));
        tick_q.push_back(mk(0, 1, 0, 1, 1));
        do_second(1'b1);
        chk("coincide_at_59", mk(0, 1, 0, 1, 1));

        // Reset mid-count discards the partial second and beats adj_min.
        do_reset();
        pulse(2, 5);
        pulse(1, 17);
        pulse(0, 33);
        chk("preload_051733", mk(5, 17, 33, 1, 0));
        run = 1'b1;
        step();
        step();
        reset   = 1'b1;
        adj_min = 1'b1;
        step();
        reset   = 1'b0;
        adj_min = 1'b0;
        chk("reset_midcount", mk(0, 0, 0, 0, 0));
        tick_q.push_back(mk(0, 0, 1, 0, 1));
        step();
        step();
        step();
        chk("no_early_tick", mk(0, 0, 0, 0, 0));
        step();
        chk("tick_after_reset", mk(0, 0, 1, 0, 1));
        run = 1'b0;
        pulse(1, 15);
        chk("color_15", mk(0, 15, 1, 15, 0));
        pulse(1, 1);
        chk("color_wrap", mk(0, 16, 1, 0, 0));

        step();
        step();
        n_cmp++;
        if (tick_q.size() != 0) begin
            n_fail++;
            $display("FAIL tick_q_drain: %0d expected ticks never seen, required 0",
                     tick_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
